// File: rtl/coax_tx_byte_packer_pkg.sv
// Shared coax word constants and the host-byte to coax-word bit mapping.
package coax_tx_byte_packer_pkg;

  localparam int unsigned COAX_WORD_WIDTH = 10;
  localparam int unsigned HIGH_BITS       = 2;
  localparam int unsigned LOW_BITS        = COAX_WORD_WIDTH - HIGH_BITS;

  // The first byte contributes only its low HIGH_BITS bits; the second byte fills the rest.
  function automatic logic [COAX_WORD_WIDTH-1:0] pack_word(input logic [HIGH_BITS-1:0] hi,
                                                          input logic [LOW_BITS-1:0]  lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/coax_tx_byte_packer.sv
// Packs host byte pairs into 10-bit coax words and feeds them to the buffered transmitter,
// with an end-of-frame start strobe and an inter-byte timeout that drops partial words.
module coax_tx_byte_packer
  import coax_tx_byte_packer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 i_in_data,
  input  logic                       i_in_valid,
  input  logic                       i_in_last,
  output logic                       o_in_ready,
  output logic [COAX_WORD_WIDTH-1:0] o_tx_data,
  output logic                       o_tx_load_strobe,
  output logic                       o_tx_start_strobe,
  input  logic                       i_tx_full,
  input  logic                       i_tx_ready,
  output logic                       o_busy,
  output logic                       o_error_strobe
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StHigh, StLow, StLoad, StStart} state_e;

  state_e                     r_state, w_state_d;
  logic [CntW-1:0]            r_cnt, w_cnt_d;
  logic [HIGH_BITS-1:0]       r_hi, w_hi_d;
  logic [COAX_WORD_WIDTH-1:0] r_tx_data, w_tx_data_d;
  logic                       r_last, w_last_d;
  logic                       r_load_strobe, w_load_d;
  logic                       r_start_strobe, w_start_d;
  logic                       r_err_strobe, w_err_d;
  logic                       w_in_ready;
  logic                       w_hs;

  // No new word starts while the buffered tx is still finishing a transmission.
  assign w_in_ready = (r_state == StHigh) ? i_tx_ready : (r_state == StLow);
  assign w_hs       = i_in_valid & w_in_ready;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_hi_d      = r_hi;
    w_tx_data_d = r_tx_data;
    w_last_d    = r_last;
    w_load_d    = 1'b0;
    w_start_d   = 1'b0;
    w_err_d     = 1'b0;
    case (r_state)
      StHigh: begin
        if (w_hs) begin
          if (i_in_last) begin
            w_err_d = 1'b1;
          end else begin
            w_hi_d    = i_in_data[HIGH_BITS-1:0];
            w_cnt_d   = '0;
            w_state_d = StLow;
          end
        end
      end
      StLow: begin
        // A handshake on the final allowed cycle still completes the word.
        if (w_hs) begin
          w_tx_data_d = pack_word(r_hi, i_in_data);
          w_last_d    = i_in_last;
          w_state_d   = StLoad;
        end else if (r_cnt == CntMax) begin
          w_err_d   = 1'b1;
          w_state_d = StHigh;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StLoad: begin
        if (!i_tx_full) begin
          w_load_d  = 1'b1;
          w_state_d = r_last ? StStart : StHigh;
        end
      end
      StStart: begin
        w_start_d = 1'b1;
        w_state_d = StHigh;
      end
      default: w_state_d = StHigh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StHigh;
      r_cnt          <= '0;
      r_hi           <= '0;
      r_tx_data      <= '0;
      r_last         <= 1'b0;
      r_load_strobe  <= 1'b0;
      r_start_strobe <= 1'b0;
      r_err_strobe   <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_hi           <= w_hi_d;
      r_tx_data      <= w_tx_data_d;
      r_last         <= w_last_d;
      r_load_strobe  <= w_load_d;
      r_start_strobe <= w_start_d;
      r_err_strobe   <= w_err_d;
    end
  end

  assign o_in_ready        = w_in_ready;
  assign o_tx_data         = r_tx_data;
  assign o_tx_load_strobe  = r_load_strobe;
  assign o_tx_start_strobe = r_start_strobe;
  assign o_error_strobe    = r_err_strobe;
  assign o_busy            = (r_state != StHigh);

endmodule

// File: tb/tb_coax_tx_byte_packer.sv
// Self-checking bench for coax_tx_byte_packer: directed scenarios plus randomized words.
module tb_coax_tx_byte_packer;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [9:0] tx_data;
  logic       tx_load_strobe;
  logic       tx_start_strobe;
  logic       tx_full = 1'b0;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       error_strobe;

  int total = 0;
  int bad = 0;
  int n_load = 0;
  int n_start = 0;
  int n_err = 0;

  coax_tx_byte_packer #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_in_data         (in_data),
    .i_in_valid        (in_valid),
    .i_in_last         (in_last),
    .o_in_ready        (in_ready),
    .o_tx_data         (tx_data),
    .o_tx_load_strobe  (tx_load_strobe),
    .o_tx_start_strobe (tx_start_strobe),
    .i_tx_full         (tx_full),
    .i_tx_ready        (tx_ready),
    .o_busy            (busy),
    .o_error_strobe    (error_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_load_strobe) n_load++;
    if (tx_start_strobe) n_start++;
    if (error_strobe) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic l);
    in_data  = d;
    in_valid = v;
    in_last  = l;
  endtask

  // One complete word: first byte, optional idle gap, second byte, optional full back-pressure.
  task automatic send_word(input string tag, input logic [7:0] b1, input logic [7:0] b2,
                           input logic last, input int gap, input int hold);
    int exp_word;
    int l0;
    int lat;
    exp_word = ((b1 % 4) * 256) + b2;
    drive(b1, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    repeat (gap) tick();
    tx_full = (hold > 0);
    drive(b2, 1'b1, last);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    chk({tag, ".data"}, 32'(tx_data), 32'(exp_word));
    l0 = n_load;
    repeat (hold) tick();
    chk({tag, ".noload_full"}, 32'(n_load - l0), 32'd0);
    tx_full = 1'b0;
    lat = 0;
    while (!tx_load_strobe && lat < 6) begin
      tick();
      lat++;
    end
    chk({tag, ".load_lat"}, 32'(lat), 32'd1);
    chk({tag, ".data_at_load"}, 32'(tx_data), 32'(exp_word));
    tick();
    chk({tag, ".start"}, 32'(tx_start_strobe), 32'(last));
  endtask

  initial begin
    int l0, s0, e0;
    int exp_starts;
    logic [7:0] b1, b2;
    logic lst;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    chk("rst.tx_data", 32'(tx_data), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.load", 32'(tx_load_strobe), 32'd0);
    chk("rst.start", 32'(tx_start_strobe), 32'd0);
    chk("rst.err", 32'(error_strobe), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    tx_ready = 1'b0;
    #1;
    chk("rst.in_ready_follow", 32'(in_ready), 32'd0);
    tx_ready = 1'b1;
    #1;

    // Pack and start
    drive(8'h02, 1'b1, 1'b0);
    tick();
    chk("ps.busy_low", 32'(busy), 32'd1);
    drive(8'h5A, 1'b1, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    chk("ps.in_ready_load", 32'(in_ready), 32'd0);
    chk("ps.data", 32'(tx_data), 32'h25A);
    chk("ps.load_n1", 32'(tx_load_strobe), 32'd0);
    tick();
    chk("ps.load_n2", 32'(tx_load_strobe), 32'd1);
    chk("ps.start_n2", 32'(tx_start_strobe), 32'd0);
    tick();
    chk("ps.load_n3", 32'(tx_load_strobe), 32'd0);
    chk("ps.start_n3", 32'(tx_start_strobe), 32'd1);
    tick();
    chk("ps.start_n4", 32'(tx_start_strobe), 32'd0);
    chk("ps.busy_end", 32'(busy), 32'd0);

    // Back-pressure
    drive(8'h01, 1'b1, 1'b0);
    tick();
    tx_full = 1'b1;
    drive(8'hFF, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    l0 = n_load;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    chk("bp.noload", 32'(n_load - l0), 32'd0);
    chk("bp.busy", 32'(busy), 32'd1);
    chk("bp.data", 32'(tx_data), 32'h1FF);
    tx_full = 1'b0;
    tick();
    chk("bp.load", 32'(tx_load_strobe), 32'd1);
    chk("bp.data_hold", 32'(tx_data), 32'h1FF);
    tick();
    chk("bp.load_once", 32'(tx_load_strobe), 32'd0);
    chk("bp.start_none", 32'(tx_start_strobe), 32'd0);

    // Timeout: error visible after the TO-th edge following the first byte
    drive(8'h03, 1'b1, 1'b0);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    e0 = n_err;
    for (int k = 1; k < TO; k++) tick();
    chk("to.no_early_err", 32'(n_err - e0), 32'd0);
    chk("to.busy_before", 32'(busy), 32'd1);
    tick();
    chk("to.err", 32'(error_strobe), 32'd1);
    chk("to.busy_after", 32'(busy), 32'd0);
    tick();
    chk("to.err_once", 32'(error_strobe), 32'd0);
    send_word("to.next", 8'h00, 8'h11, 1'b0, 0, 0);

    // Framing error on a first byte flagged as last
    l0 = n_load;
    drive(8'h7F, 1'b1, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    chk("fe.err", 32'(error_strobe), 32'd1);
    chk("fe.busy", 32'(busy), 32'd0);
    repeat (3) tick();
    chk("fe.noload", 32'(n_load - l0), 32'd0);

    // Gating: tx_ready low blocks acceptance in HIGH
    tx_ready = 1'b0;
    drive(8'h02, 1'b1, 1'b0);
    #1;
    chk("gate.in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    chk("gate.busy", 32'(busy), 32'd0);
    drive(8'h00, 1'b0, 1'b0);
    tx_ready = 1'b1;
    tick();

    // Reset mid-LOAD
    drive(8'h02, 1'b1, 1'b0);
    tick();
    tx_full = 1'b1;
    drive(8'h33, 1'b1, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    tick();
    chk("rl.busy_load", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_full = 1'b0;
    l0 = n_load;
    s0 = n_start;
    chk("rl.data", 32'(tx_data), 32'd0);
    chk("rl.busy", 32'(busy), 32'd0);
    repeat (4) tick();
    chk("rl.noload", 32'(n_load - l0), 32'd0);
    chk("rl.nostart", 32'(n_start - s0), 32'd0);

    // Multi-word frame
    l0 = n_load;
    s0 = n_start;
    send_word("mw0", 8'h01, 8'h10, 1'b0, 0, 0);
    send_word("mw1", 8'h02, 8'h20, 1'b0, 2, 0);
    send_word("mw2", 8'h03, 8'h30, 1'b1, 0, 0);
    tick();
    chk("mw.loads", 32'(n_load - l0), 32'd3);
    chk("mw.starts", 32'(n_start - s0), 32'd1);

    // Randomized words against the arithmetic word model
    l0 = n_load;
    s0 = n_start;
    exp_starts = 0;
    for (int i = 0; i < 24; i++) begin
      b1  = 8'($urandom);
      b2  = 8'($urandom);
      lst = 1'($urandom_range(0, 1));
      if (lst) exp_starts++;
      send_word($sformatf("rnd%0d", i), b1, b2, lst, int'($urandom_range(0, TO - 2)),
                int'($urandom_range(0, 4)));
    end
    tick();
    chk("rnd.loads", 32'(n_load - l0), 32'd24);
    chk("rnd.starts", 32'(n_start - s0), 32'(exp_starts));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coax_tx_byte_packer.md
Name: coax_tx_byte_packer

Overview:
- Host-side stage directly upstream of coax_buffered_tx.
- Accepts a byte stream from the host interface (valid/ready, with an end-of-frame marker) and packs byte pairs into 10-bit coax words.
- Writes each word into the buffered transmitter with a load strobe, respecting its full flag.
- Issues a start strobe at end of frame and discards partial words after an inter-byte timeout.

Parameters:
- TIMEOUT, 1024: cycles allowed between the first and second byte of a word before the partial word is discarded. Must be ≥ 2. Counter width is clog2(TIMEOUT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data  in  8  host byte
- in_valid  in  1  host byte valid
- in_last  in  1  byte is the final byte of the frame; meaningful only on the second byte of a word
- in_ready  out  1  byte accepted when in_valid && in_ready at a rising edge
- tx_data  out  10  word to buffered tx data
- tx_load_strobe  out  1  to buffered tx load_strobe
- tx_start_strobe  out  1  to buffered tx start_strobe
- tx_full  in  1  from buffered tx full
- tx_ready  in  1  from buffered tx ready
- busy  out  1  high whenever state != HIGH
- error_strobe  out  1  one-cycle pulse on framing error or timeout

Behaviour:
- Word format:
  - first byte: bits[1:0] -> word[9:8]; bits[7:2] ignored.
  - second byte: -> word[7:0].
- States: HIGH, LOW, LOAD, START. Encoding is 2 bits.
- Outputs tx_load_strobe, tx_start_strobe and error_strobe are registered: each goes high in the cycle after the decision, for exactly one cycle.
- HIGH state:
  - in_ready = tx_ready. No new word is accepted while the buffered tx is finishing a transmission.
  - On handshake with in_last=0: latch bits[1:0], clear the timeout counter, go to LOW.
  - On handshake with in_last=1: byte is dropped, error_strobe is pulsed, state stays HIGH.
- LOW state:
  - in_ready = 1. The counter increments every cycle without a handshake.
  - On handshake: assemble tx_data, latch in_last into last_q, go to LOAD.
  - If the counter reaches TIMEOUT-1 without a handshake: discard the partial word, pulse error_strobe, go to HIGH.
  - If a handshake and timeout coincide, the handshake wins.
- LOAD state:
  - in_ready = 0.
  - If tx_full=0: schedule tx_load_strobe, then go to START if last_q, else to HIGH.
  - If tx_full=1: stay in LOAD, holding tx_data.
- START state:
  - in_ready = 0. Schedule tx_start_strobe, go to HIGH.
- tx_data stability: held from assembly until at least the cycle after tx_load_strobe. It updates only on a second-byte handshake.
- Latency: second byte accepted at edge N -> tx_load_strobe high in cycle N+2 (tx_full=0) -> tx_start_strobe high in cycle N+3 if in_last was set.
- Full-flag spacing: consecutive loads are at least 3 cycles apart, so tx_full is never stale from our own previous write.
- Reset values:
  - state = HIGH; counter = 0; tx_data = 0; last_q = 0.
  - all strobes = 0.
  - in_ready follows tx_ready in the first post-reset cycle.
- Reset mid-word or mid-LOAD: the partial word is discarded and no strobe is emitted after reset.

Decomposition:
- Shared coax package: constant COAX_WORD_WIDTH = 10 and the byte-to-word bit mapping (HIGH_BITS = 2).
- State encodings stay local.
- No sub-module is needed; the timeout counter is inline. A single module, roughly 150–200 lines.

Test Plan:
- Pack and start: send bytes 0x02, 0x5A (last=1) with tx_full=0 -> tx_data=0x25A, load_strobe high at N+2, start_strobe high at N+3, exactly one pulse each.
- Back-pressure: tx_full=1 before the second byte 0xFF of (0x01, 0xFF) -> stays in LOAD, in_ready=0, no strobe. Release tx_full after 10 cycles -> tx_data=0x1FF, load_strobe one cycle later.
- Timeout: TIMEOUT=16, send 0x03 then nothing -> error_strobe at cycle 16 after the first-byte edge, busy=0, next pair 0x00, 0x11 yields tx_data=0x011.
- Framing error and gating: first byte sent with in_last=1 -> error_strobe, no load. With tx_ready=0 in HIGH -> in_ready=0 and no byte is consumed.
- Reset mid-LOAD: assert reset while in LOAD with tx_full=1 -> after reset no load_strobe, tx_data=0, busy=0.
- Multi-word frame: three words (last on the third) -> three load_strobes, exactly one start_strobe, one cycle after the third load_strobe.
